// File: rtl/branch_hazard_pkg.sv
// Shared types and constants for the ID-stage branch hazard controller.
// The optional stall counter is compiled in with BRANCH_STALL_CNT_EN.
package branch_hazard_pkg;

    localparam int REG_AW_DEF = 5;
    // Slots store the destination zero-extended to a fixed width so the struct
    // stays usable for any REG_AW up to this bound.
    localparam int REG_AW_MAX = 8;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b10;
    localparam logic [1:0] FWD_WB = 2'b01;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_AW_MAX-1:0] write_reg;
    } slot_t;

endpackage

// File: rtl/branch_hazard_match.sv
// Per-operand hazard decision: picks the forward source for one branch
// operand, or flags that it cannot be supplied yet.
module branch_hazard_match
    import branch_hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  slot_t             slot_ex,
    input  slot_t             slot_mem,
    input  slot_t             slot_wb,
    output logic [1:0]        fwd,
    output logic              stall
);

    logic [REG_AW_MAX-1:0] src_ext;
    logic                  src_live;
    logic                  hit_ex;
    logic                  hit_mem;
    logic                  hit_wb;
    logic                  unused_mem_read;

    assign src_ext  = REG_AW_MAX'(src);
    // $0 is hardwired, so it never depends on an in-flight write.
    assign src_live = use_src && (src != '0);

    assign hit_ex  = src_live && slot_ex.valid  && slot_ex.reg_write  && (slot_ex.write_reg  == src_ext);
    assign hit_mem = src_live && slot_mem.valid && slot_mem.reg_write && (slot_mem.write_reg == src_ext);
    assign hit_wb  = src_live && slot_wb.valid  && slot_wb.reg_write  && (slot_wb.write_reg  == src_ext);

    assign unused_mem_read = slot_mem.mem_read ^ slot_wb.mem_read;

    // Youngest producer wins; MEM has no forwarding path, so it always waits.
    always_comb begin
        fwd   = FWD_RF;
        stall = 1'b0;
        if (hit_ex) begin
            if (slot_ex.mem_read) begin
                stall = 1'b1;
            end else begin
                fwd = FWD_EX;
            end
        end else if (hit_mem) begin
            stall = 1'b1;
        end else if (hit_wb) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/branch_hazard_unit.sv
// Branch-operand forwarding, stall and IF-flush control for the ID-stage
// comparator. Define BRANCH_STALL_CNT_EN to build the saturating stall counter.
module branch_hazard_unit
    import branch_hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Branch_ID,
    input  logic              UseRs_ID,
    input  logic              UseRt_ID,
    input  logic [REG_AW-1:0] Rs_ID,
    input  logic [REG_AW-1:0] Rt_ID,
    input  logic              RegWrite_ID,
    input  logic              MemRead_ID,
    input  logic [REG_AW-1:0] WriteReg_ID,
    input  logic              BranchTaken_ID,
    output logic [1:0]        ForwardA1,
    output logic [1:0]        ForwardB1,
    output logic              Stall,
    output logic              BubbleEX,
    output logic              FlushIF,
    output logic [CNT_W-1:0]  StallCycles
);

    slot_t      slot_ex;
    slot_t      slot_mem;
    slot_t      slot_wb;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_a;
    logic       stall_b;
    logic       stall;

    branch_hazard_match #(.REG_AW(REG_AW)) u_match_a (
        .src      (Rs_ID),
        .use_src  (UseRs_ID),
        .slot_ex  (slot_ex),
        .slot_mem (slot_mem),
        .slot_wb  (slot_wb),
        .fwd      (fwd_a),
        .stall    (stall_a)
    );

    branch_hazard_match #(.REG_AW(REG_AW)) u_match_b (
        .src      (Rt_ID),
        .use_src  (UseRt_ID),
        .slot_ex  (slot_ex),
        .slot_mem (slot_mem),
        .slot_wb  (slot_wb),
        .fwd      (fwd_b),
        .stall    (stall_b)
    );

    assign stall     = Branch_ID & (stall_a | stall_b);
    assign Stall     = stall;
    assign BubbleEX  = stall;
    assign ForwardA1 = stall ? FWD_RF : fwd_a;
    assign ForwardB1 = stall ? FWD_RF : fwd_b;
    assign FlushIF   = Branch_ID & BranchTaken_ID & ~stall;

    // A stalled branch stays in ID, so EX receives a bubble in its place.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_ex  <= '0;
            slot_mem <= '0;
            slot_wb  <= '0;
        end else begin
            slot_wb  <= slot_mem;
            slot_mem <= slot_ex;
            if (stall) begin
                slot_ex <= '0;
            end else begin
                slot_ex.valid     <= 1'b1;
                slot_ex.reg_write <= RegWrite_ID;
                slot_ex.mem_read  <= MemRead_ID;
                slot_ex.write_reg <= REG_AW_MAX'(WriteReg_ID);
            end
        end
    end

`ifdef BRANCH_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign StallCycles = stall_cnt;
`else
    assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit; counter expectations follow
// BRANCH_STALL_CNT_EN.
module tb_branch_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Branch_ID;
    logic        UseRs_ID;
    logic        UseRt_ID;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic        RegWrite_ID;
    logic        MemRead_ID;
    logic [4:0]  WriteReg_ID;
    logic        BranchTaken_ID;
    logic [1:0]  ForwardA1;
    logic [1:0]  ForwardB1;
    logic        Stall;
    logic        BubbleEX;
    logic        FlushIF;
    logic [31:0] StallCycles;

    int n_vec = 0;
    int n_err = 0;

    // Packed view {ForwardA1, ForwardB1, Stall, BubbleEX, FlushIF}
    logic [6:0] obs;
    assign obs = {ForwardA1, ForwardB1, Stall, BubbleEX, FlushIF};

    branch_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .Branch_ID      (Branch_ID),
        .UseRs_ID       (UseRs_ID),
        .UseRt_ID       (UseRt_ID),
        .Rs_ID          (Rs_ID),
        .Rt_ID          (Rt_ID),
        .RegWrite_ID    (RegWrite_ID),
        .MemRead_ID     (MemRead_ID),
        .WriteReg_ID    (WriteReg_ID),
        .BranchTaken_ID (BranchTaken_ID),
        .ForwardA1      (ForwardA1),
        .ForwardB1      (ForwardB1),
        .Stall          (Stall),
        .BubbleEX       (BubbleEX),
        .FlushIF        (FlushIF),
        .StallCycles    (StallCycles)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Present one ID-stage instruction and let the combinational outputs settle.
    task automatic set_id(input logic br, input logic urs, input logic urt,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic rw, input logic mr, input logic [4:0] wr,
                          input logic taken);
        Branch_ID      = br;
        UseRs_ID       = urs;
        UseRt_ID       = urt;
        Rs_ID          = rs;
        Rt_ID          = rt;
        RegWrite_ID    = rw;
        MemRead_ID     = mr;
        WriteReg_ID    = wr;
        BranchTaken_ID = taken;
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        set_id(0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] exp_cnt;
        exp_cnt = 32'd0;
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        n_vec++;
        if (obs !== 7'b00_00_0_0_0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 7'b0000000);
        end
        n_vec++;
        if (StallCycles !== exp_cnt) begin
            n_err++;
            $display("[TB] FAIL reset_count: got %0d expected %0d", StallCycles, exp_cnt);
        end
    endtask

    task automatic test_load_use;
        logic [31:0] exp_cnt;
`ifdef BRANCH_STALL_CNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 1, 5'd3, 0);      // lw $3
        n_vec++;
        if (obs !== 7'b00_00_0_0_0) begin
            n_err++;
            $display("[TB] FAIL load_issue: got %b expected %b", obs, 7'b0000000);
        end
        next_cycle();
        set_id(1, 1, 1, 5'd3, 5'd4, 0, 0, 5'd0, 0);      // beq $3,$4
        n_vec++;
        if (obs !== 7'b00_00_1_1_0) begin
            n_err++;
            $display("[TB] FAIL load_stall1: got %b expected %b", obs, 7'b0000110);
        end
        next_cycle();
        set_id(1, 1, 1, 5'd3, 5'd4, 0, 0, 5'd0, 0);
        n_vec++;
        if (obs !== 7'b00_00_1_1_0) begin
            n_err++;
            $display("[TB] FAIL load_stall2: got %b expected %b", obs, 7'b0000110);
        end
        next_cycle();
        set_id(1, 1, 1, 5'd3, 5'd4, 0, 0, 5'd0, 0);
        n_vec++;
        if (obs !== 7'b01_00_0_0_0) begin
            n_err++;
            $display("[TB] FAIL load_resolved: got %b expected %b", obs, 7'b0100000);
        end
        n_vec++;
        if (StallCycles !== exp_cnt) begin
            n_err++;
            $display("[TB] FAIL load_count: got %0d expected %0d", StallCycles, exp_cnt);
        end
    endtask

    task automatic test_ex_forward;
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd5, 0);      // add $5
        next_cycle();
        set_id(1, 1, 1, 5'd5, 5'd5, 0, 0, 5'd0, 0);      // beq $5,$5
        n_vec++;
        if (obs !== 7'b10_10_0_0_0) begin
            n_err++;
            $display("[TB] FAIL ex_forward: got %b expected %b", obs, 7'b1010000);
        end
    endtask

    task automatic test_mem_stall;
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd6, 0);      // add $6
        next_cycle();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd9, 0);      // unrelated add $9
        next_cycle();
        set_id(1, 1, 1, 5'd0, 5'd6, 0, 0, 5'd0, 0);      // bne $0,$6
        n_vec++;
        if (obs !== 7'b00_00_1_1_0) begin
            n_err++;
            $display("[TB] FAIL mem_stall: got %b expected %b", obs, 7'b0000110);
        end
        next_cycle();
        set_id(1, 1, 1, 5'd0, 5'd6, 0, 0, 5'd0, 0);
        n_vec++;
        if (obs !== 7'b00_01_0_0_0) begin
            n_err++;
            $display("[TB] FAIL mem_resolved: got %b expected %b", obs, 7'b0001000);
        end
    endtask

    task automatic test_zero_reg;
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 1, 5'd0, 0);      // lw $0
        next_cycle();
        set_id(1, 1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0);      // beq $0,$0
        n_vec++;
        if (obs !== 7'b00_00_0_0_0) begin
            n_err++;
            $display("[TB] FAIL zero_reg: got %b expected %b", obs, 7'b0000000);
        end
    endtask

    task automatic test_flush;
        do_reset();
        set_id(1, 1, 1, 5'd1, 5'd2, 0, 0, 5'd0, 1);      // taken beq, no hazard
        n_vec++;
        if (obs !== 7'b00_00_0_0_1) begin
            n_err++;
            $display("[TB] FAIL flush_taken: got %b expected %b", obs, 7'b0000001);
        end
        next_cycle();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 1, 5'd8, 0);      // lw $8
        next_cycle();
        set_id(1, 1, 1, 5'd8, 5'd1, 0, 0, 5'd0, 1);      // taken beq $8,$1
        n_vec++;
        if (obs !== 7'b00_00_1_1_0) begin
            n_err++;
            $display("[TB] FAIL flush_stalled1: got %b expected %b", obs, 7'b0000110);
        end
        next_cycle();
        set_id(1, 1, 1, 5'd8, 5'd1, 0, 0, 5'd0, 1);
        n_vec++;
        if (obs !== 7'b00_00_1_1_0) begin
            n_err++;
            $display("[TB] FAIL flush_stalled2: got %b expected %b", obs, 7'b0000110);
        end
        next_cycle();
        set_id(1, 1, 1, 5'd8, 5'd1, 0, 0, 5'd0, 1);
        n_vec++;
        if (obs !== 7'b01_00_0_0_1) begin
            n_err++;
            $display("[TB] FAIL flush_after_stall: got %b expected %b", obs, 7'b0100001);
        end
    endtask

    task automatic test_reset_mid_stall;
        logic [31:0] exp_cnt;
        exp_cnt = 32'd0;
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 1, 5'd3, 0);      // lw $3
        next_cycle();
        set_id(1, 1, 1, 5'd3, 5'd4, 0, 0, 5'd0, 0);
        next_cycle();
        set_id(1, 1, 1, 5'd3, 5'd4, 0, 0, 5'd0, 0);
        n_vec++;
        if (obs !== 7'b00_00_1_1_0) begin
            n_err++;
            $display("[TB] FAIL midrst_before: got %b expected %b", obs, 7'b0000110);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_id(1, 1, 1, 5'd3, 5'd4, 0, 0, 5'd0, 0);
        n_vec++;
        if (obs !== 7'b00_00_0_0_0) begin
            n_err++;
            $display("[TB] FAIL midrst_after: got %b expected %b", obs, 7'b0000000);
        end
        n_vec++;
        if (StallCycles !== exp_cnt) begin
            n_err++;
            $display("[TB] FAIL midrst_count: got %0d expected %0d", StallCycles, exp_cnt);
        end
    endtask

    task automatic test_both_operands;
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd7, 0);      // add $7
        next_cycle();
        set_id(0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);      // non-writing op
        next_cycle();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd2, 0);      // add $2
        next_cycle();
        set_id(1, 1, 1, 5'd2, 5'd7, 0, 0, 5'd0, 0);      // beq $2,$7
        n_vec++;
        if (obs !== 7'b10_01_0_0_0) begin
            n_err++;
            $display("[TB] FAIL both_operands: got %b expected %b", obs, 7'b1001000);
        end
    endtask

    task automatic test_ex_over_wb;
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd4, 0);      // add $4 (older)
        next_cycle();
        set_id(0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        next_cycle();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd4, 0);      // add $4 (younger)
        next_cycle();
        set_id(1, 1, 0, 5'd4, 5'd4, 0, 0, 5'd0, 0);      // Rt not used
        n_vec++;
        if (obs !== 7'b10_00_0_0_0) begin
            n_err++;
            $display("[TB] FAIL ex_over_wb: got %b expected %b", obs, 7'b1000000);
        end
    endtask

    task automatic test_non_branch;
        do_reset();
        set_id(0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd10, 0);     // add $10
        next_cycle();
        set_id(0, 1, 0, 5'd10, 5'd0, 1, 1, 5'd11, 1);    // lw $11 reading $10
        n_vec++;
        if (obs !== 7'b10_00_0_0_0) begin
            n_err++;
            $display("[TB] FAIL nonbranch_fwd: got %b expected %b", obs, 7'b1000000);
        end
        next_cycle();
        set_id(0, 0, 1, 5'd0, 5'd11, 0, 0, 5'd0, 1);     // reader of $11, not a branch
        n_vec++;
        if (obs !== 7'b00_00_0_0_0) begin
            n_err++;
            $display("[TB] FAIL nonbranch_nostall: got %b expected %b", obs, 7'b0000000);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_id(0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        test_reset();
        test_load_use();
        test_ex_forward();
        test_mem_stall();
        test_zero_reg();
        test_flush();
        test_reset_mid_stall();
        test_both_operands();
        test_ex_over_wb();
        test_non_branch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
